// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: lane select and extension on loads,
// read-modify-write for sub-word stores, misaligned requests rejected without touching memory.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_d_in,
    output logic              mem_mrd,
    output logic              mem_mwr,
    input  logic [31:0]       mem_d_out
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;

    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_word;
    logic [31:0] merged;

    always_comb begin
        misaligned = 1'b0;
        if (op == OP_LW || op == OP_SW)
            misaligned = |addr[1:0];
        else if (op == OP_LH || op == OP_LHU || op == OP_SH)
            misaligned = addr[0];
    end

    // Little-endian lanes: byte k of the word lives at bits [8k+7:8k].
    always_comb begin
        lane_b = mem_d_out[{addr_q, 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_d_out[31:16] : mem_d_out[15:0];
        case (op_q)
            OP_LH:   load_word = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_word = {16'h0000, lane_h};
            OP_LB:   load_word = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_word = {24'h000000, lane_b};
            default: load_word = mem_d_out;
        endcase
    end

    always_comb begin
        merged = mem_d_out;
        if (op_q == OP_SB)
            merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // mem_d_in doubles as the merge register: it is only non-zero while mem_mwr is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            mem_adr  <= '0;
            mem_d_in <= '0;
            mem_mrd  <= 1'b0;
            mem_mwr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr[1:0];
                        wdata_q <= wdata;
                        mem_adr <= {addr[ADDR_W-1:2], 2'b00};
                        ready   <= 1'b0;
                        if (misaligned) begin
                            state <= S_RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (op <= OP_LBU) begin
                            state   <= S_RD;
                            mem_mrd <= 1'b1;
                        end else if (op == OP_SW) begin
                            state    <= S_WR;
                            mem_mwr  <= 1'b1;
                            mem_d_in <= wdata;
                        end else begin
                            state   <= S_RMW_RD;
                            mem_mrd <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    rdata   <= load_word;
                    mem_mrd <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_RESP;
                end
                S_WR, S_RMW_WR: begin
                    mem_mwr  <= 1'b0;
                    mem_d_in <= '0;
                    done     <= 1'b1;
                    state    <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_mrd  <= 1'b0;
                    mem_mwr  <= 1'b1;
                    mem_d_in <= merged;
                    state    <= S_RMW_WR;
                end
                S_RESP: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= '0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    ready    <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    rdata    <= '0;
                    mem_d_in <= '0;
                    mem_mrd  <= 1'b0;
                    mem_mwr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory behind the port, a transaction-level reference
// model predicting every cycle of the handshake, directed cases and a randomized phase.
module tb_load_store_unit;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mem_mrd, mem_mwr;
    logic [31:0] rdata, mem_adr, mem_d_in, mem_d_out;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
        .mem_d_out(mem_d_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        if (i == 250) return 32'h80FF7F01;
        return (32'(i) * 32'h01000193) ^ 32'hA5A55A5A;
    endfunction

    // data memory: combinational read, write on the clock edge
    logic        init_mem = 1'b1;
    logic [31:0] mem [0:1023];
    assign mem_d_out = mem[mem_adr[11:2]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (mem_mwr) begin
            mem[mem_adr[11:2]] <= mem_d_in;
        end
    end

    // reference model: one outstanding transaction, described by its accept cycle and latency
    logic [31:0] ref_mem [0:1023];
    int          cyc = 0;
    bit          busy = 1'b0;
    int          t_a, t_lat, t_wr_off;
    bit          t_err, t_rd, t_wr;
    logic [31:0] t_rdata, t_word, t_adr;
    logic [9:0]  t_idx;
    int          accepts = 0;
    int          aborted = 0;

    always @(posedge clk) begin
        bit          was_idle;
        logic [31:0] w, b, h, mask;
        int          sh;
        cyc++;
        if (init_mem)
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        if (!rst_n) begin
            if (busy) aborted++;
            busy = 1'b0;
        end else begin
            was_idle = !busy;
            if (busy && cyc == t_a + t_lat) begin
                busy = 1'b0;
                if (t_wr) ref_mem[t_idx] = t_word;
            end
            if (was_idle && req) begin
                accepts++;
                busy    = 1'b1;
                t_a     = cyc;
                t_idx   = addr[11:2];
                t_adr   = {addr[31:2], 2'b00};
                w       = ref_mem[t_idx];
                sh      = 8 * int'(addr[1:0]);
                b       = (w >> sh) & 32'hFF;
                h       = (w >> (16 * int'(addr[1]))) & 32'hFFFF;
                t_err   = ((op == LW || op == SW) && addr[1:0] != 2'b00) ||
                          ((op == LH || op == LHU || op == SH) && addr[0]);
                t_rd    = 1'b0;
                t_wr    = 1'b0;
                t_rdata = '0;
                t_word  = '0;
                t_wr_off = 0;
                if (t_err) begin
                    t_lat = 1;
                end else if (op <= LBU) begin
                    t_lat = 2;
                    t_rd  = 1'b1;
                    case (op)
                        LW:      t_rdata = w;
                        LH:      t_rdata = h[15] ? (h | 32'hFFFF0000) : h;
                        LHU:     t_rdata = h;
                        LB:      t_rdata = b[7] ? (b | 32'hFFFFFF00) : b;
                        default: t_rdata = b;
                    endcase
                end else if (op == SW) begin
                    t_lat  = 2;
                    t_wr   = 1'b1;
                    t_word = wdata;
                end else begin
                    t_lat    = 3;
                    t_rd     = 1'b1;
                    t_wr     = 1'b1;
                    t_wr_off = 1;
                    if (op == SB) begin
                        mask   = 32'hFF << sh;
                        t_word = (w & ~mask) | ((wdata & 32'hFF) << sh);
                    end else begin
                        mask   = 32'hFFFF << (16 * int'(addr[1]));
                        t_word = (w & ~mask) | ((wdata & 32'hFFFF) << (16 * int'(addr[1])));
                    end
                end
            end
        end
    end

    // compare process: every output, every cycle, away from the active edge
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          done_count = 0, mrd_count = 0, mwr_count = 0;

    always @(negedge clk) begin
        bit e_done, e_rd, e_wr;
        if (rst_n && !init_mem) begin
            e_done = busy && cyc == t_a + t_lat - 1;
            e_rd   = busy && t_rd && cyc == t_a;
            e_wr   = busy && t_wr && cyc == t_a + t_wr_off;
            chk("ready", 32'(ready), 32'(!busy));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_done && t_err));
            chk("rdata", rdata, e_done ? t_rdata : 32'h0);
            chk("mem_mrd", 32'(mem_mrd), 32'(e_rd));
            chk("mem_mwr", 32'(mem_mwr), 32'(e_wr));
            chk("mem_d_in", mem_d_in, e_wr ? t_word : 32'h0);
            if (e_rd || e_wr) chk("mem_adr", mem_adr, t_adr);
            if (done) begin
                last_rdata = rdata;
                last_err   = err;
                done_count++;
            end
            if (mem_mrd) mrd_count++;
            if (mem_mwr) mwr_count++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        op = o; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        int m0, r0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        #1 rst_n = 1'b1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);

        do_req(LB, 32'h3E9, 32'h0);  chk("lb_3e9", last_rdata, 32'h0000007F);
        do_req(LB, 32'h3EA, 32'h0);  chk("lb_3ea", last_rdata, 32'hFFFFFFFF);
        do_req(LBU, 32'h3EA, 32'h0); chk("lbu_3ea", last_rdata, 32'h000000FF);
        do_req(LH, 32'h3EA, 32'h0);  chk("lh_3ea", last_rdata, 32'hFFFF80FF);
        do_req(LHU, 32'h3E8, 32'h0); chk("lhu_3e8", last_rdata, 32'h00007F01);

        m0 = mwr_count;
        do_req(SW, 32'h3EC, 32'hDEADBEEF);
        chk("sw_mwr_pulses", 32'(mwr_count - m0), 32'd1);
        do_req(LW, 32'h3EC, 32'h0);  chk("lw_3ec", last_rdata, 32'hDEADBEEF);

        do_req(SB, 32'h3E9, 32'h123456AB); chk("sb_word", mem[250], 32'h80FFAB01);
        do_req(SH, 32'h3EA, 32'hCAFE1234); chk("sh_word", mem[250], 32'h1234AB01);

        m0 = mwr_count; r0 = mrd_count;
        do_req(LW, 32'h3EA, 32'h0); chk("mis_lw_err", 32'(last_err), 32'd1);
        do_req(LH, 32'h3E9, 32'h0); chk("mis_lh_err", 32'(last_err), 32'd1);
        chk("mis_no_rd", 32'(mrd_count - r0), 32'd0);
        chk("mis_no_wr", 32'(mwr_count - m0), 32'd0);
        chk("mis_word", mem[250], 32'h1234AB01);

        // reset while the sub-word store is in its read phase
        wait_idle();
        m0 = mwr_count;
        op = SB; addr = 32'h3E8; wdata = 32'h000000CC; req = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_ctrl", {28'h0, done, err, mem_mrd, mem_mwr}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_d_in", mem_d_in, 32'h0);
        chk("arst_adr", mem_adr, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle();
        chk("arst_word", mem[250], 32'h1234AB01);
        chk("arst_no_wr", 32'(mwr_count - m0), 32'd0);

        // req held high with rotating ops
        for (int k = 0; k < 30; k++) begin
            case (k % 5)
                0: op = LW;
                1: op = SW;
                2: op = LB;
                3: op = SB;
                default: op = LHU;
            endcase
            addr = 32'h3E0 + 32'(4 * (k % 8)) + 32'(k % 2);
            wdata = $urandom;
            req = 1'b1;
            @(negedge clk);
        end
        req = 1'b0;
        wait_idle();

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            req   = ($urandom_range(0, 3) != 0);
            op    = 3'($urandom_range(0, 7));
            addr  = $urandom_range(32'h3C0, 32'h3FF);
            wdata = $urandom;
            @(negedge clk);
        end
        req = 1'b0;
        wait_idle();

        chk("done_per_accept", 32'(done_count), 32'(accepts - aborted));
        for (int i = 0; i < 1024; i++)
            if (i >= 240 && i < 256) chk("mem_final", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
